// File: rtl/proc_pkg.sv
// Shared processor constants: D/X decode values, rstatus codes and multdiv FSM encoding.
package proc_pkg;

  localparam logic [4:0] OPC_ALU    = 5'b00000;
  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  localparam logic [2:0] RSTATUS_MULT = 3'd4;
  localparam logic [2:0] RSTATUS_DIV  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2,
    MD_DONE  = 2'd3
  } md_state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

  function automatic logic is_md_req(input logic valid, input logic [4:0] opcode,
                                     input logic [4:0] aluop);
    return valid && (opcode == OPC_ALU) && ((aluop == ALUOP_MULT) || (aluop == ALUOP_DIV));
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// D/X decode inputs, multdiv unit handshake and pipeline control outputs of the multdiv controller.
interface multdiv_ctrl_if;
  logic       dx_valid;
  logic [4:0] dx_opcode;
  logic [4:0] dx_aluop;
  logic       md_data_rdy;
  logic       md_exception;
  logic       ctrl_mult;
  logic       ctrl_div;
  logic       stall;
  logic       result_we;
  logic       rstatus_we;
  logic [2:0] rstatus_code;
  logic       busy;

  modport master (
    output dx_valid, dx_opcode, dx_aluop, md_data_rdy, md_exception,
    input  ctrl_mult, ctrl_div, stall, result_we, rstatus_we, rstatus_code, busy
  );

  modport slave (
    input  dx_valid, dx_opcode, dx_aluop, md_data_rdy, md_exception,
    output ctrl_mult, ctrl_div, stall, result_we, rstatus_we, rstatus_code, busy
  );
endinterface

// File: rtl/md_timer.sv
// Saturating wait counter for the multdiv controller; tc flags the last allowed WAIT cycle.
module md_timer #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  if ((TIMEOUT < 1) || ((2 ** CNT_W) <= TIMEOUT)) begin : g_bad_params
    $error("md_timer: need TIMEOUT >= 1 and 2**CNT_W > TIMEOUT");
  end

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    tc = (cnt_q == TC_VAL);
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Multdiv pipeline controller: launches mult/div, stalls the front end, forces a timeout abort.
module multdiv_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = 6
) (
  input  logic         clock,
  input  logic         reset_n,
  multdiv_ctrl_if.slave bus
);

  md_state_e state_q, state_d;
  md_op_e    kind_q, kind_d;
  logic      exc_q, exc_d;
  logic      to_q, to_d;
  logic      tmr_clear, tmr_en, tmr_tc;
  logic      req;
  logic      rs_flag;

  md_timer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (tmr_clear),
    .en     (tmr_en),
    .tc     (tmr_tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      kind_q  <= OP_MULT;
      exc_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      exc_q   <= exc_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    exc_d     = exc_q;
    to_d      = to_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    req       = is_md_req(bus.dx_valid, bus.dx_opcode, bus.dx_aluop);
    case (state_q)
      MD_IDLE: begin
        if (req) begin
          state_d = MD_START;
          kind_d  = (bus.dx_aluop == ALUOP_DIV) ? OP_DIV : OP_MULT;
        end
      end
      MD_START: begin
        tmr_clear = 1'b1;
        exc_d     = 1'b0;
        to_d      = 1'b0;
        state_d   = MD_WAIT;
      end
      MD_WAIT: begin
        tmr_en = 1'b1;
        // A result arriving on the terminal-count cycle takes priority over the abort.
        if (bus.md_data_rdy) begin
          exc_d   = bus.md_exception;
          state_d = MD_DONE;
        end else if (tmr_tc) begin
          to_d    = 1'b1;
          state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  always_comb begin
    rs_flag          = (state_q == MD_DONE) && (exc_q || to_q);
    bus.ctrl_mult    = (state_q == MD_START) && (kind_q == OP_MULT);
    bus.ctrl_div     = (state_q == MD_START) && (kind_q == OP_DIV);
    // Gated by reset_n so a request held in D/X cannot keep stall high during reset.
    bus.stall        = ((state_q == MD_IDLE) && req && reset_n) ||
                       (state_q == MD_START) || (state_q == MD_WAIT);
    bus.result_we    = (state_q == MD_DONE);
    bus.rstatus_we   = rs_flag;
    bus.rstatus_code = rs_flag ? ((kind_q == OP_DIV) ? RSTATUS_DIV : RSTATUS_MULT) : '0;
    bus.busy         = (state_q != MD_IDLE);
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: vector table of single transactions plus back-to-back and reset sequences.
module tb_multdiv_ctrl;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  multdiv_ctrl_if bus();

  multdiv_ctrl #(
    .TIMEOUT(40),
    .CNT_W  (6)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic       valid;
    logic [4:0] opc;
    logic [4:0] aluop;
    int         rdy_cyc;  // cycle md_data_rdy is pulsed, -1 = never
    logic       exc;      // md_exception on the rdy cycle (held 1 otherwise)
    int         start;    // 0 none, 1 mult, 2 div
    int         done;     // cycle result_we is expected
    logic       rs_we;
    logic [2:0] code;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] opc, input logic [4:0] alu,
                       input logic rdy, input logic exc);
    bus.dx_valid     = v;
    bus.dx_opcode    = opc;
    bus.dx_aluop     = alu;
    bus.md_data_rdy  = rdy;
    bus.md_exception = exc;
  endtask

  task automatic chk_all(input string tag, input logic st, input logic cm, input logic cd,
                         input logic rw, input logic sw, input logic [2:0] code, input logic bz);
    chk({tag, " stall"}, 32'(bus.stall), 32'(st));
    chk({tag, " ctrl_mult"}, 32'(bus.ctrl_mult), 32'(cm));
    chk({tag, " ctrl_div"}, 32'(bus.ctrl_div), 32'(cd));
    chk({tag, " result_we"}, 32'(bus.result_we), 32'(rw));
    chk({tag, " rstatus_we"}, 32'(bus.rstatus_we), 32'(sw));
    chk({tag, " rstatus_code"}, 32'(bus.rstatus_code), 32'(code));
    chk({tag, " busy"}, 32'(bus.busy), 32'(bz));
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'b00000, 5'b00110,  5, 1'b0, 1,  6, 1'b0, 3'd0};
    vecs[1]  = '{1'b1, 5'b00000, 5'b00111,  3, 1'b1, 2,  4, 1'b1, 3'd5};
    vecs[2]  = '{1'b1, 5'b00000, 5'b00110,  2, 1'b0, 1,  3, 1'b0, 3'd0};
    vecs[3]  = '{1'b1, 5'b00000, 5'b00111,  2, 1'b0, 2,  3, 1'b0, 3'd0};
    vecs[4]  = '{1'b1, 5'b00000, 5'b00110,  4, 1'b1, 1,  5, 1'b1, 3'd4};
    vecs[5]  = '{1'b1, 5'b00000, 5'b00110, -1, 1'b0, 1, 42, 1'b1, 3'd4};
    vecs[6]  = '{1'b1, 5'b00000, 5'b00111, -1, 1'b0, 2, 42, 1'b1, 3'd5};
    vecs[7]  = '{1'b0, 5'b00000, 5'b00110,  2, 1'b0, 0,  0, 1'b0, 3'd0};
    vecs[8]  = '{1'b1, 5'b00010, 5'b00111,  2, 1'b0, 0,  0, 1'b0, 3'd0};
    vecs[9]  = '{1'b1, 5'b00000, 5'b00101,  2, 1'b0, 0,  0, 1'b0, 3'd0};
    vecs[10] = '{1'b1, 5'b00000, 5'b00110, 41, 1'b0, 1, 42, 1'b0, 3'd0};
    vecs[11] = '{1'b1, 5'b00000, 5'b00111, 40, 1'b0, 2, 41, 1'b0, 3'd0};
    vecs[12] = '{1'b1, 5'b00000, 5'b00110,  0, 1'b0, 1, 42, 1'b1, 3'd4};
    vecs[13] = '{1'b1, 5'b00000, 5'b00111,  1, 1'b0, 2, 42, 1'b1, 3'd5};

    // Reset with a request already present in D/X.
    drive(1'b1, 5'b00000, 5'b00110, 1'b1, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    drive(1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    for (int i = 0; i < NV; i++) begin
      vec_t v;
      int   last;
      logic started;
      v = vecs[i];
      started = (v.start != 0);
      last = started ? v.done : 3;
      for (int c = 0; c <= last + 1; c++) begin
        logic exp_res;
        drive((c <= last) ? v.valid : 1'b0, v.opc, v.aluop, (c == v.rdy_cyc),
              (c == v.rdy_cyc) ? v.exc : 1'b1);
        @(negedge clock);
        exp_res = started && (c == v.done);
        chk_all($sformatf("v%0d c%0d", i, c),
                started && (c < v.done),
                (c == 1) && (v.start == 1),
                (c == 1) && (v.start == 2),
                exp_res,
                exp_res && v.rs_we,
                exp_res ? v.code : 3'd0,
                started && (c >= 1) && (c <= v.done));
        next_cycle();
      end
    end

    // Back-to-back: mult completes, div presented in the very next IDLE cycle.
    drive(1'b1, 5'b00000, 5'b00110, 1'b0, 1'b0);
    @(negedge clock); chk_all("b2b c0", 1, 0, 0, 0, 0, 3'd0, 0); next_cycle();
    @(negedge clock); chk_all("b2b c1", 1, 1, 0, 0, 0, 3'd0, 1); next_cycle();
    drive(1'b1, 5'b00000, 5'b00110, 1'b1, 1'b0);
    @(negedge clock); chk_all("b2b c2", 1, 0, 0, 0, 0, 3'd0, 1); next_cycle();
    drive(1'b1, 5'b00000, 5'b00110, 1'b0, 1'b0);
    @(negedge clock); chk_all("b2b c3", 0, 0, 0, 1, 0, 3'd0, 1); next_cycle();
    drive(1'b1, 5'b00000, 5'b00111, 1'b0, 1'b0);
    @(negedge clock); chk_all("b2b c4", 1, 0, 0, 0, 0, 3'd0, 0); next_cycle();
    @(negedge clock); chk_all("b2b c5", 1, 0, 1, 0, 0, 3'd0, 1); next_cycle();
    drive(1'b1, 5'b00000, 5'b00111, 1'b1, 1'b1);
    @(negedge clock); chk_all("b2b c6", 1, 0, 0, 0, 0, 3'd0, 1); next_cycle();
    drive(1'b1, 5'b00000, 5'b00111, 1'b0, 1'b0);
    @(negedge clock); chk_all("b2b c7", 0, 0, 0, 1, 1, 3'd5, 1); next_cycle();
    drive(1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0);
    @(negedge clock); chk_all("b2b c8", 0, 0, 0, 0, 0, 3'd0, 0); next_cycle();

    // Reset pulsed in WAIT at cycle 4 with the request still held.
    drive(1'b1, 5'b00000, 5'b00110, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) next_cycle();
    @(negedge clock); chk_all("rst c4 pre", 1, 0, 0, 0, 0, 3'd0, 1);
    #1 reset_n = 1'b0;
    #1 chk_all("rst c4 asserted", 0, 0, 0, 0, 0, 3'd0, 0);
    next_cycle();
    reset_n = 1'b1;
    drive(1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0);
    for (int c = 5; c < 10; c++) begin
      drive(1'b0, 5'b00000, 5'b00000, (c == 6), 1'b1);
      @(negedge clock);
      chk_all($sformatf("rst c%0d", c), 0, 0, 0, 0, 0, 3'd0, 0);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 40, the maximum number of WAIT cycles before a forced abort.
REQ-002 Parameter CNT_W, default 6, the wait-counter width; the design SHALL require 2**CNT_W > TIMEOUT.
REQ-003 clock  in  1  single clock; all state SHALL change on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 dx_valid  in  1  D/X latch holds a real instruction, not a bubble.
REQ-006 dx_opcode  in  5  opcode field in D/X.
REQ-007 dx_aluop  in  5  ALU-op field in D/X.
REQ-008 md_data_rdy  in  1  multiplier/divider result valid.
REQ-009 md_exception  in  1  multiplier overflow or divide-by-zero; sampled with md_data_rdy.
REQ-010 ctrl_mult  out  1  one-cycle start pulse to the multiplier.
REQ-011 ctrl_div  out  1  one-cycle start pulse to the divider.
REQ-012 stall  out  1  freezes PC, F/D and D/X; inserts a bubble into X/M.
REQ-013 result_we  out  1  X/M captures the multdiv result this cycle.
REQ-014 rstatus_we  out  1  X/M writes rstatus this cycle.
REQ-015 rstatus_code  out  3  rstatus value: 4 for mult, 5 for div; 0 otherwise.
REQ-016 busy  out  1  state is not IDLE.

Function
REQ-017 A multdiv request is dx_valid=1, dx_opcode=00000 and dx_aluop equal to 00110 (mult) or 00111 (div); every other combination SHALL be ignored.
REQ-018 FSM states: IDLE, START, WAIT, DONE.
REQ-019 IDLE: on a request, go to START and latch the op kind (mult or div); otherwise stay in IDLE.
REQ-020 START: assert ctrl_mult or ctrl_div (per the latched kind) for exactly this one cycle, clear the counter, and go to WAIT.
REQ-021 WAIT: increment the counter by 1 each cycle; md_data_rdy=1 goes to DONE; if counter==TIMEOUT-1 with md_data_rdy=0, go to DONE and set the internal timeout flag.
REQ-022 If md_data_rdy and the timeout condition occur in the same cycle, md_data_rdy SHALL win and no timeout is flagged.
REQ-023 md_data_rdy in IDLE, START or DONE SHALL be ignored.
REQ-024 DONE: assert result_we=1 for one cycle, then return to IDLE unconditionally.
REQ-025 In DONE, if md_exception was sampled with md_data_rdy or timeout is set, assert rstatus_we=1 with rstatus_code=4 (mult) or 5 (div); otherwise rstatus_we=0 and rstatus_code=0.
REQ-026 On a timeout, result_we SHALL still pulse so that X/M captures zero data; the datapath zeroes the data when rstatus_we=1.
REQ-027 stall SHALL be combinationally high in IDLE while a request is present, and high throughout START and WAIT.
REQ-028 stall SHALL be low in DONE, so the multdiv instruction advances at the end of DONE.
REQ-029 A request present in IDLE immediately after DONE is a new instruction and SHALL start a new operation with no idle gap.
REQ-030 Minimum latency: request seen in cycle 0, start pulse in cycle 1, md_data_rdy earliest in cycle 2, result_we in cycle 3; stall is high for cycles 0-2.
REQ-031 ctrl_mult and ctrl_div SHALL never be asserted together.
REQ-032 The counter SHALL saturate and never wrap.

Reset
REQ-033 When reset_n=0, the state SHALL become IDLE asynchronously, and the counter, op kind and timeout flag SHALL clear.
REQ-034 All registered outputs SHALL be 0 during reset.
REQ-035 Reset asserted mid-operation SHALL abort the operation with no result_we or rstatus_we pulse; after release the block is in IDLE.

Structure
REQ-036 Opcode and ALU-op constants (00000, 00110, 00111), the rstatus codes 4 and 5, and the state encoding SHALL live in the shared processor package proc_pkg.
REQ-037 The wait counter with its saturation and terminal-count compare SHALL be one sub-module, md_timer; the FSM and output decode SHALL remain in multdiv_ctrl.

Verification
REQ-038 mult request, md_data_rdy at cycle 5 with md_exception=0 -> ctrl_mult pulses at cycle 1; stall is high for cycles 0-5; result_we=1 at cycle 6; rstatus_we=0.
REQ-039 div request, md_data_rdy=1 with md_exception=1 at cycle 3 -> ctrl_div pulses at cycle 1; result_we=1, rstatus_we=1 and rstatus_code=5 at cycle 4.
REQ-040 mult request, md_data_rdy never asserted, TIMEOUT=40 -> result_we=1, rstatus_we=1 and rstatus_code=4 exactly 42 cycles after the request.
REQ-041 Back-to-back mult then div -> the second start pulse occurs one cycle after the first DONE, with no bubble between them.
REQ-042 reset_n pulsed low in WAIT at cycle 4 -> all outputs drop to 0 immediately; no result_we pulse follows; busy=0.
REQ-043 dx_valid=0 with opcode=00000 and aluop=00110, and dx_valid=1 with aluop=00111 but opcode=00010 -> neither causes stall or a start pulse.
